// File: rtl/cache_bus_pkg.sv
// Shared command encodings and widths for the CPU<->cache bus (bus 1) and the
// cache<->memory bus (bus 2).
package cache_bus_pkg;

  localparam int BITS_IN_BYTE = 8;
  localparam int C1_CMD_W     = 3;
  localparam int C2_CMD_W     = 3;

  typedef enum logic [C1_CMD_W-1:0] {
    C1_NOP             = 3'd0,
    C1_READ8           = 3'd1,
    C1_READ16          = 3'd2,
    C1_READ32          = 3'd3,
    C1_WRITE8          = 3'd4,
    C1_WRITE16         = 3'd5,
    C1_WRITE32         = 3'd6,
    C1_INVALIDATE_LINE = 3'd7
  } c1_cmd_e;

  // Bus 1 has only eight code points. The cache answers with the invalidate
  // code, which it drives only while the master has released the bus.
  localparam c1_cmd_e C1_RESPONSE = C1_INVALIDATE_LINE;

  typedef enum logic [C2_CMD_W-1:0] {
    C2_NOP        = 3'd0,
    C2_READ_LINE  = 3'd1,
    C2_WRITE_LINE = 3'd2,
    C2_RESPONSE   = 3'd3
  } c2_cmd_e;

  function automatic logic c1_is_write(input c1_cmd_e cmd);
    return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
  endfunction

endpackage

// File: rtl/bus_req_fifo.sv
// Synchronous request queue with full/empty/count; DEPTH must be a power of 2.
module bus_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cpu_bus_master.sv
// CPU-side bus-1 master: queues requests, runs the split-address/multi-beat
// transfer, hands the bus to the cache and returns read data or a timeout.
module cpu_bus_master
  import cache_bus_pkg::*;
#(
  parameter int TAG_SET_W  = 15,
  parameter int OFFSET_W   = 4,
  parameter int DATA1_W    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [2:0]                    req_cmd,
  input  logic [TAG_SET_W+OFFSET_W-1:0] req_addr,
  input  logic [2*DATA1_W-1:0]          req_wdata,
  output logic                          resp_valid,
  output logic [2*DATA1_W-1:0]          resp_rdata,
  output logic                          resp_err,
  output logic [TAG_SET_W-1:0]          addr1,
  inout  wire  [DATA1_W-1:0]            data1,
  inout  wire  [2:0]                    cmd1,
  output logic                          busy,
  output logic [CNT_W-1:0]              n_req,
  output logic [CNT_W-1:0]              n_wait
);

  localparam int ADDR_W = TAG_SET_W + OFFSET_W;
  localparam int REQ_W  = C1_CMD_W + ADDR_W + 2*DATA1_W;
  localparam int TMR_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_AHI, S_ALO, S_WD1, S_REL, S_WAIT, S_RB1, S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic                   own_q, own_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [2*DATA1_W-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       n_req_q, n_req_d, n_wait_q, n_wait_d;
  c1_cmd_e                wrk_cmd_q, wrk_cmd_d;
  logic [ADDR_W-1:0]      wrk_addr_q, wrk_addr_d;
  logic [2*DATA1_W-1:0]   wrk_wdata_q, wrk_wdata_d;

  c1_cmd_e                cmd_drv;
  logic [DATA1_W-1:0]     data_drv;
  logic                   data_en;
  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REQ_W-1:0]       fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  function automatic logic [2*DATA1_W-1:0] first_beat(input c1_cmd_e cmd,
                                                      input logic [DATA1_W-1:0] d);
    case (cmd)
      C1_READ8:             return {{(2*DATA1_W-BITS_IN_BYTE){1'b0}}, d[BITS_IN_BYTE-1:0]};
      C1_READ16, C1_READ32: return {{DATA1_W{1'b0}}, d};
      default:              return '0;
    endcase
  endfunction

  // NOP requests carry no transfer and are never queued.
  assign fifo_push = req_valid && req_ready && (req_cmd != C1_NOP);
  assign req_ready = !fifo_full;

  bus_req_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata ({req_cmd, req_addr, req_wdata}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cmd1       = own_q ? cmd_drv : 3'bz;
  assign data1      = (own_q && data_en) ? data_drv : {DATA1_W{1'bz}};
  assign resp_valid = (state_q == S_DONE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q && (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE) || (fifo_count != '0);
  assign n_req      = n_req_q;
  assign n_wait     = n_wait_q;

  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    timer_d     = timer_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    n_req_d     = n_req_q;
    n_wait_d    = n_wait_q;
    wrk_cmd_d   = wrk_cmd_q;
    wrk_addr_d  = wrk_addr_q;
    wrk_wdata_d = wrk_wdata_q;
    cmd_drv     = C1_NOP;
    data_drv    = '0;
    data_en     = 1'b0;
    addr1       = '0;
    fifo_pop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          wrk_cmd_d   = c1_cmd_e'(fifo_rdata[REQ_W-1 -: C1_CMD_W]);
          wrk_addr_d  = fifo_rdata[2*DATA1_W +: ADDR_W];
          wrk_wdata_d = fifo_rdata[2*DATA1_W-1:0];
          rdata_d     = '0;
          err_d       = 1'b0;
          state_d     = S_AHI;
        end
      end
      S_AHI: begin
        cmd_drv = wrk_cmd_q;
        addr1   = wrk_addr_q[OFFSET_W +: TAG_SET_W];
        state_d = S_ALO;
      end
      S_ALO: begin
        addr1    = TAG_SET_W'(wrk_addr_q[OFFSET_W-1:0]);
        data_en  = c1_is_write(wrk_cmd_q);
        data_drv = wrk_wdata_q[DATA1_W-1:0];
        state_d  = (wrk_cmd_q == C1_WRITE32) ? S_WD1 : S_REL;
      end
      S_WD1: begin
        data_en  = 1'b1;
        data_drv = wrk_wdata_q[2*DATA1_W-1:DATA1_W];
        state_d  = S_REL;
      end
      S_REL: begin
        own_d   = 1'b0;
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        n_wait_d = n_wait_q + CNT_W'(1);
        if (cmd1 == C1_RESPONSE) begin
          rdata_d = first_beat(wrk_cmd_q, data1);
          if (wrk_cmd_q == C1_READ32) begin
            state_d = S_RB1;
          end else begin
            own_d   = 1'b1;
            state_d = S_DONE;
          end
        end else if (timer_q == TMR_W'(TIMEOUT)) begin
          // Reclaim the bus; any later answer from the cache is ignored.
          err_d   = 1'b1;
          own_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_RB1: begin
        rdata_d[2*DATA1_W-1:DATA1_W] = data1;
        own_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        n_req_d = n_req_q + CNT_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      own_q    <= 1'b1;
      timer_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      n_req_q  <= '0;
      n_wait_q <= '0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      timer_q  <= timer_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      n_req_q  <= n_req_d;
      n_wait_q <= n_wait_d;
    end
  end

  always_ff @(posedge clk) begin
    wrk_cmd_q   <= wrk_cmd_d;
    wrk_addr_q  <= wrk_addr_d;
    wrk_wdata_q <= wrk_wdata_d;
  end

endmodule

// File: tb/tb_cpu_bus_master.sv
// Bench for cpu_bus_master: scripted cache responder on bus 1, scoreboard of
// expected responses, and a monitor that checks every resp_valid pulse.
module tb_cpu_bus_master;
  import cache_bus_pkg::*;

  localparam int TOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_cmd;
  logic [18:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [14:0] addr1;
  wire  [15:0] data1;
  wire  [2:0]  cmd1;
  logic        busy;
  logic [31:0] n_req, n_wait;

  logic        rsp_cmd_en, rsp_data_en;
  logic [2:0]  rsp_cmd;
  logic [15:0] rsp_data;

  assign cmd1  = rsp_cmd_en  ? rsp_cmd  : 3'bz;
  assign data1 = rsp_data_en ? rsp_data : 16'bz;

  cpu_bus_master #(
    .TAG_SET_W(15), .OFFSET_W(4), .DATA1_W(16),
    .FIFO_DEPTH(4), .TIMEOUT(TOUT), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .addr1(addr1), .data1(data1), .cmd1(cmd1),
    .busy(busy), .n_req(n_req), .n_wait(n_wait)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cmd;
    logic [18:0] addr;
    logic [31:0] wdata;
    bit          silent;
    int          delay;
    logic [15:0] d0;
    logic [15:0] d1;
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  txn_t scr_q[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   model_req = 0;
  int   model_wait = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input txn_t t);
    exp_t e;
    e.err   = t.silent;
    e.rdata = 32'h0;
    if (!t.silent) begin
      case (t.cmd)
        C1_READ8:  e.rdata = {24'h0, t.d0[7:0]};
        C1_READ16: e.rdata = {16'h0, t.d0};
        C1_READ32: e.rdata = {t.d1, t.d0};
        default:   e.rdata = 32'h0;
      endcase
    end
    return e;
  endfunction

  // Caller is aligned just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] cmd, input logic [18:0] addr, input logic [31:0] wd,
                      input bit silent, input int delay, input logic [15:0] d0,
                      input logic [15:0] d1);
    txn_t t;
    int   n;
    t.cmd = cmd; t.addr = addr; t.wdata = wd; t.silent = silent;
    t.delay = delay; t.d0 = d0; t.d1 = d1;
    req_cmd = cmd; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 400);
    if (!req_ready) chk("ready_wait", 32'(req_ready), 32'd1);
    @(posedge clk);
    if (req_ready && cmd != C1_NOP) begin
      scr_q.push_back(t);
      exp_q.push_back(model(t));
      model_req++;
      model_wait += silent ? (TOUT + 1) : (delay + 1);
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 600);
    chk("idle_reached", 32'(busy || exp_q.size() != 0), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_n_req"}, n_req, 32'(model_req));
    chk({tag, "_n_wait"}, n_wait, 32'(model_wait));
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", 32'(resp_err), 32'(e.err));
        end
      end
    end
  end

  // Cache responder: checks the address/data phases, then answers after the scripted delay.
  initial begin
    txn_t s;
    rsp_cmd_en = 1'b0; rsp_data_en = 1'b0; rsp_cmd = C1_NOP; rsp_data = 16'h0;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && cmd1 != C1_NOP) begin
        if (scr_q.size() == 0) begin
          chk("unexpected_bus_cmd", 32'(cmd1), 32'(C1_NOP));
        end else begin
          s = scr_q.pop_front();
          chk("bus_cmd", 32'(cmd1), 32'(s.cmd));
          chk("addr1_hi", 32'(addr1), 32'(s.addr[18:4]));
          @(negedge clk);
          chk("addr1_lo", 32'(addr1), 32'(s.addr[3:0]));
          if (s.cmd == C1_WRITE8 || s.cmd == C1_WRITE16 || s.cmd == C1_WRITE32)
            chk("data1_beat0", 32'(data1), 32'(s.wdata[15:0]));
          if (s.cmd == C1_WRITE32) begin
            @(negedge clk);
            chk("data1_beat1", 32'(data1), 32'(s.wdata[31:16]));
          end
          if (!s.silent) begin
            repeat (2 + s.delay) @(posedge clk);
            #1;
            rsp_cmd = C1_RESPONSE; rsp_cmd_en = 1'b1;
            rsp_data = s.d0; rsp_data_en = 1'b1;
            if (s.cmd == C1_READ32) begin
              @(posedge clk);
              #1;
              rsp_cmd_en = 1'b0;
              rsp_data = s.d1;
            end
            @(posedge clk);
            #1;
            rsp_cmd_en = 1'b0; rsp_data_en = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int lat;
    int w0;
    bit rdy;
    logic [2:0] c;
    reset = 1'b1; req_valid = 1'b0; req_cmd = 3'd0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_cmd1", 32'(cmd1), 32'(C1_NOP));
    chk("rst_addr1", 32'(addr1), 32'd0);
    chk("rst_n_req", n_req, 32'd0);
    chk("rst_n_wait", n_wait, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // READ8, answer on the fourth WAIT cycle, plus request-to-response latency
    send(C1_READ8, 19'h00012, 32'h0, 1'b0, 3, 16'hBEEF, 16'h0);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (resp_valid !== 1'b1 && lat < 100);
    chk("t1_latency", 32'(lat), 32'd8);
    @(posedge clk);
    #1;
    wait_idle();
    chk("t1_n_req", n_req, 32'd1);
    check_counters("t1");

    send(C1_WRITE32, 19'h00100, 32'hCAFEF00D, 1'b0, 1, 16'h0, 16'h0);
    wait_idle();
    check_counters("t2");

    send(C1_READ32, 19'h1A5C3, 32'h0, 1'b0, 2, 16'h1111, 16'h2222);
    wait_idle();
    check_counters("t3");

    // Back-to-back offers against a stalled cache: five accepted, sixth blocked.
    for (int i = 0; i < 6; i++) begin
      txn_t t;
      t.cmd = 3'($urandom_range(1, 7)); t.addr = 19'($urandom); t.wdata = $urandom;
      t.silent = 1'b0; t.delay = 8; t.d0 = 16'($urandom); t.d1 = 16'($urandom);
      req_cmd = t.cmd; req_addr = t.addr; req_wdata = t.wdata; req_valid = 1'b1;
      @(negedge clk);
      rdy = req_ready;
      chk("t4_req_ready", 32'(rdy), (i < 5) ? 32'd1 : 32'd0);
      @(posedge clk);
      if (rdy) begin
        scr_q.push_back(t);
        exp_q.push_back(model(t));
        model_req++;
        model_wait += t.delay + 1;
      end
      #1;
    end
    req_valid = 1'b0;
    wait_idle();
    check_counters("t4");

    // Silent cache: timeout after TOUT+1 WAIT cycles, bus reclaimed.
    w0 = int'(n_wait);
    send(C1_READ16, 19'h7FFF0, 32'h0, 1'b1, 0, 16'h0, 16'h0);
    wait_idle();
    chk("t5_wait_cycles", n_wait - 32'(w0), 32'(TOUT + 1));
    @(negedge clk);
    chk("t5_cmd1_nop", 32'(cmd1), 32'(C1_NOP));
    @(posedge clk);
    #1;
    check_counters("t5");

    // NOP request is dropped without a response.
    send(C1_NOP, 19'h12345, 32'h0, 1'b0, 0, 16'h0, 16'h0);
    repeat (20) @(posedge clk);
    #1;
    wait_idle();
    check_counters("t6");

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      c = 3'($urandom_range(1, 7));
      send(c, 19'($urandom), $urandom, ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 6)), 16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle();
    check_counters("t7");

    // Reset while waiting for the cache, with a second request still queued.
    send(C1_READ8, 19'h00ABC, 32'h0, 1'b1, 0, 16'h0, 16'h0);
    send(C1_READ16, 19'h00DEF, 32'h0, 1'b1, 0, 16'h0, 16'h0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    scr_q.delete();
    model_req = 0;
    model_wait = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t8_cmd1_nop", 32'(cmd1), 32'(C1_NOP));
    chk("t8_resp_valid", 32'(resp_valid), 32'd0);
    chk("t8_busy", 32'(busy), 32'd0);
    chk("t8_req_ready", 32'(req_ready), 32'd1);
    check_counters("t8");
    repeat (30) @(negedge clk);
    chk("t8_still_idle", 32'(busy), 32'd0);
    check_counters("t8_late");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
